// File: rtl/bsg_axil_debug_req_seq_pkg.sv
// Shared types and defaults for the multi-hart AXI-Lite debug-request sequencer.
package bsg_axil_debug_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_issue,
        e_resp,
        e_next
    } state_e;

    typedef enum logic [1:0] {
        e_step_npc,
        e_step_irq_hi,
        e_step_irq_lo,
        e_step_freeze
    } step_e;

    localparam logic [1:0]  axil_resp_okay_gp       = 2'b00;
    localparam logic [31:0] default_hart_stride_gp  = 32'h0100_0000;
    localparam logic [31:0] default_npc_addr_gp     = 32'h0020_0010;
    localparam logic [31:0] default_npc_data_gp     = 32'h0013_0800;
    localparam logic [31:0] default_irq_addr_gp     = 32'h0030_c000;
    localparam logic [31:0] default_freeze_addr_gp  = 32'h0020_0008;

    function automatic int unsigned lg_min1(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_axil_debug_req_seq_if.sv
// AXI-Lite write-only bus (AW, W, B) between the debug sequencer and the config space.
interface bsg_axil_debug_req_seq_if #(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned data_width_p = 32
);
    logic [addr_width_p-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/bsg_axil_debug_req_seq_arb.sv
// Combinational round-robin pick: lowest requesting index at or above ptr_i, wrapping.
module bsg_arb_round_robin
    import bsg_axil_debug_pkg::*;
#(
    parameter  int unsigned width_p     = 4,
    localparam int unsigned lg_width_lp = lg_min1(width_p)
) (
    input  logic [width_p-1:0]     reqs_i,
    input  logic [lg_width_lp-1:0] ptr_i,
    output logic                   v_o,
    output logic [lg_width_lp-1:0] sel_o
);
    logic hi_found;

    // First pass covers [ptr, width); second pass wraps to [0, ptr).
    always_comb begin
        v_o      = 1'b0;
        sel_o    = '0;
        hi_found = 1'b0;
        for (int unsigned j = 0; j < width_p; j++) begin
            if (!hi_found && reqs_i[j] && (j >= 32'(ptr_i))) begin
                hi_found = 1'b1;
                sel_o    = lg_width_lp'(j);
            end
        end
        if (hi_found) begin
            v_o = 1'b1;
        end else begin
            for (int unsigned j = 0; j < width_p; j++) begin
                if (!v_o && reqs_i[j]) begin
                    v_o   = 1'b1;
                    sel_o = lg_width_lp'(j);
                end
            end
        end
    end
endmodule

// File: rtl/bsg_axil_debug_req_seq.sv
// Converts per-hart debug halt requests and freeze commands into AXI-Lite write
// sequences (NPC, IRQ raise, IRQ lower), one write outstanding, round-robin over harts.
module bsg_axil_debug_req_seq
    import bsg_axil_debug_pkg::*;
#(
    parameter  int unsigned num_harts_p       = 4,
    parameter  int unsigned axil_addr_width_p = 32,
    parameter  int unsigned axil_data_width_p = 32,
    parameter  logic [31:0] hart_stride_p     = default_hart_stride_gp,
    parameter  logic [31:0] npc_addr_p        = default_npc_addr_gp,
    parameter  logic [31:0] npc_data_p        = default_npc_data_gp,
    parameter  logic [31:0] irq_addr_p        = default_irq_addr_gp,
    parameter  logic [31:0] freeze_addr_p     = default_freeze_addr_gp,
    parameter  bit          send_npc_p        = 1'b1,
    localparam int unsigned hart_w_lp         = lg_min1(num_harts_p)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [num_harts_p-1:0] debug_req_i,
    input  logic                   freeze_v_i,
    input  logic [hart_w_lp-1:0]   freeze_hart_i,
    input  logic                   freeze_val_i,
    output logic                   freeze_ready_and_o,
    output logic                   busy_o,
    output logic [num_harts_p-1:0] err_o,
    input  logic                   err_clr_i,
    bsg_axil_debug_req_seq_if.master m_axil
);
    state_e                 state_r;
    step_e                  step_r;
    logic [hart_w_lp-1:0]   hart_r, ptr_r;
    logic                   freeze_val_r;
    logic                   awvalid_r, wvalid_r, bready_r, ready_r;
    logic                   aw_done_r, w_done_r;
    logic [num_harts_p-1:0] armed_r, err_r;

    logic                   grant_v;
    logic [hart_w_lp-1:0]   grant_hart;
    logic                   aw_fin, w_fin, last_step, seq_done, resp_err;
    logic [num_harts_p-1:0] armed_clr, err_set;
    logic [axil_addr_width_p-1:0] step_base;

    bsg_arb_round_robin #(.width_p(num_harts_p)) arb (
        .reqs_i (debug_req_i & armed_r),
        .ptr_i  (ptr_r),
        .v_o    (grant_v),
        .sel_o  (grant_hart)
    );

    assign aw_fin    = aw_done_r | (awvalid_r & m_axil.awready);
    assign w_fin     = w_done_r  | (wvalid_r  & m_axil.wready);
    assign last_step = (step_r == e_step_irq_lo) || (step_r == e_step_freeze);
    assign seq_done  = (state_r == e_next) && (step_r == e_step_irq_lo);
    assign resp_err  = (state_r == e_resp) && bready_r && m_axil.bvalid
                       && (m_axil.bresp != axil_resp_okay_gp);

    always_comb begin
        armed_clr = '0;
        err_set   = '0;
        for (int unsigned h = 0; h < num_harts_p; h++) begin
            armed_clr[h] = seq_done && (hart_r == hart_w_lp'(h));
            err_set[h]   = resp_err && (hart_r == hart_w_lp'(h));
        end
    end

    // Clear beats re-arm in the completion cycle so a low request re-arms one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_r <= '1;
            err_r   <= '0;
        end else begin
            armed_r <= (armed_r | ~debug_req_i) & ~armed_clr;
            err_r   <= (err_clr_i ? '0 : err_r) | err_set;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= e_idle;
            step_r       <= e_step_npc;
            hart_r       <= '0;
            ptr_r        <= '0;
            freeze_val_r <= 1'b0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            ready_r      <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
        end else begin
            unique case (state_r)
                e_idle: begin
                    ready_r <= 1'b1;
                    if (freeze_v_i && ready_r) begin
                        hart_r       <= freeze_hart_i;
                        freeze_val_r <= freeze_val_i;
                        step_r       <= e_step_freeze;
                        awvalid_r    <= 1'b1;
                        wvalid_r     <= 1'b1;
                        ready_r      <= 1'b0;
                        state_r      <= e_issue;
                    end else if (grant_v) begin
                        hart_r    <= grant_hart;
                        step_r    <= send_npc_p ? e_step_npc : e_step_irq_hi;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        ready_r   <= 1'b0;
                        state_r   <= e_issue;
                    end
                end
                e_issue: begin
                    if (m_axil.awready) awvalid_r <= 1'b0;
                    if (m_axil.wready)  wvalid_r  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= e_resp;
                    end else begin
                        aw_done_r <= aw_fin;
                        w_done_r  <= w_fin;
                    end
                end
                e_resp: begin
                    if (m_axil.bvalid) begin
                        bready_r <= 1'b0;
                        state_r  <= e_next;
                    end
                end
                e_next: begin
                    if (last_step) begin
                        ptr_r   <= (hart_r == hart_w_lp'(num_harts_p - 1)) ? '0 : hart_r + 1'b1;
                        ready_r <= 1'b1;
                        state_r <= e_idle;
                    end else begin
                        step_r    <= (step_r == e_step_npc) ? e_step_irq_hi : e_step_irq_lo;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        state_r   <= e_issue;
                    end
                end
            endcase
        end
    end

    always_comb begin
        m_axil.wdata = '0;
        unique case (step_r)
            e_step_npc: begin
                step_base    = axil_addr_width_p'(npc_addr_p);
                m_axil.wdata = axil_data_width_p'(npc_data_p);
            end
            e_step_irq_hi: begin
                step_base       = axil_addr_width_p'(irq_addr_p);
                m_axil.wdata[0] = 1'b1;
            end
            e_step_irq_lo: begin
                step_base = axil_addr_width_p'(irq_addr_p);
            end
            e_step_freeze: begin
                step_base       = axil_addr_width_p'(freeze_addr_p);
                m_axil.wdata[0] = freeze_val_r;
            end
        endcase
    end

    assign m_axil.awaddr  = step_base
                          + axil_addr_width_p'(hart_r) * axil_addr_width_p'(hart_stride_p);
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_r;
    assign m_axil.wstrb   = '1;
    assign m_axil.wvalid  = wvalid_r;
    assign m_axil.bready  = bready_r;

    assign freeze_ready_and_o = ready_r;
    assign busy_o             = (state_r != e_idle);
    assign err_o              = err_r;
endmodule
